// File: rtl/pc_sequencer.sv
// Program-counter controller for the single-cycle MIPS core: selects PC+4, branch
// or jump target each cycle, with stall hold, a post-reset settle cycle and a redirect counter.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [15:0]      imm,
    input  logic [25:0]      jaddr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             redirect_reg, redirect_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             load;
    logic             taken;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] branch_target;

    assign pc_plus4      = pc_reg + WIDTH'(4);
    assign jump_target   = {pc_plus4[WIDTH-1:WIDTH-4], jaddr, 2'b00};
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            INIT: state_next = RUN;
            RUN: begin
                if (stall) state_next = HOLD;
                else       load       = 1'b1;
            end
            HOLD: begin
                if (!stall) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Jump beats a taken branch; either one counts as a single redirect.
    always_comb begin
        taken         = load & (jump | (branch & zero));
        pc_next       = pc_reg;
        redirect_next = taken;
        cnt_next      = cnt_reg;
        if (load) begin
            if (jump)                pc_next = jump_target;
            else if (branch && zero) pc_next = branch_target;
            else                     pc_next = pc_plus4;
        end
        if (taken && (cnt_reg != {CNT_W{1'b1}}))
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= INIT;
            pc_reg       <= RESET_PC;
            redirect_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            redirect_reg <= redirect_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign pc        = pc_reg;
    assign pc_valid  = (state_reg != INIT);
    assign redirect  = redirect_reg;
    assign taken_cnt = cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized check of pc_sequencer against a cycle-level behavioural model
// of the PC rules (reset settle, stall drop, jump/branch priority, saturating count).
module tb_pc_sequencer;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int          CNT_W    = 2;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             branch = 1'b0;
    logic             zero = 1'b0;
    logic             jump = 1'b0;
    logic [15:0]      imm = '0;
    logic [25:0]      jaddr = '0;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pc_valid;
    logic             redirect;
    logic [CNT_W-1:0] taken_cnt;

    pc_sequencer #(
        .WIDTH   (WIDTH),
        .RESET_PC(RESET_PC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .imm      (imm),
        .jaddr    (jaddr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .pc_valid (pc_valid),
        .redirect (redirect),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: "settled" is true once the post-reset cycle has passed.
    bit          m_settled;
    logic [31:0] m_pc;
    bit          m_redirect;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [31:0] seq;
        logic [31:0] off;
        if (!rst_n) begin
            m_settled  = 0;
            m_pc       = RESET_PC;
            m_redirect = 0;
            m_cnt      = 0;
        end else if (!m_settled) begin
            m_settled  = 1;
            m_redirect = 0;
        end else if (stall) begin
            m_redirect = 0;
        end else begin
            seq = m_pc + 32'd4;
            off = 32'($signed(imm)) * 32'd4;
            if (jump) begin
                m_pc = (seq & 32'hF000_0000) | (32'(jaddr) * 32'd4);
                m_redirect = 1;
            end else if (branch && zero) begin
                m_pc = seq + off;
                m_redirect = 1;
            end else begin
                m_pc = seq;
                m_redirect = 0;
            end
            if (m_redirect && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit b, input bit z, input bit j,
                         input logic [15:0] im, input logic [25:0] ja);
        rst_n = r; stall = s; branch = b; zero = z; jump = j; imm = im; jaddr = ja;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        $display("cyc %0d rst_n=%0b stall=%0b br=%0b z=%0b j=%0b imm=%h ja=%h -> pc=%h valid=%0b redir=%0b cnt=%0d",
                 cyc, r, s, b, z, j, im, ja, pc, pc_valid, redirect, taken_cnt);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("pc_valid", 32'(pc_valid), 32'(m_settled));
        chk("redirect", 32'(redirect), 32'(m_redirect));
        chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    endtask

    initial begin
        // Reset held with a jump request, then settle cycle
        repeat (3) cycle(0, 0, 0, 0, 1, 16'h0, 26'h40);
        cycle(1, 0, 0, 0, 0, 16'h0, 26'h0);
        // Sequential wrap FFFF_FFF8 -> FFFF_FFFC -> 0
        cycle(1, 0, 0, 0, 0, 16'h0, 26'h0);
        cycle(1, 0, 0, 0, 0, 16'h0, 26'h0);
        chk("wrap_pc", pc, 32'h0000_0000);
        // Jump to 0x100
        cycle(1, 0, 0, 0, 1, 16'h0, 26'h40);
        chk("jump_pc", pc, 32'h0000_0100);
        // Taken branch back one word from 0x100
        cycle(1, 0, 1, 1, 0, 16'hFFFE, 26'h0);
        chk("branch_pc", pc, 32'h0000_00FC);
        // Not-taken branch
        cycle(1, 0, 1, 0, 0, 16'hFFFE, 26'h0);
        chk("nt_branch_pc", pc, 32'h0000_0100);
        // Jump and taken branch together: counted once
        cycle(1, 0, 1, 1, 1, 16'h0010, 26'h40);
        chk("prio_cnt", 32'(taken_cnt), 32'd3);
        // Stall three cycles with jump requested, then release
        repeat (3) cycle(1, 1, 0, 0, 1, 16'h0, 26'h123);
        cycle(1, 0, 0, 0, 1, 16'h0, 26'h123);
        chk("unstall_jump_pc", pc, 32'h0000_048C);
        // Saturation
        repeat (3) cycle(1, 0, 0, 0, 1, 16'h0, 26'h200);
        chk("sat_cnt", 32'(taken_cnt), 32'd3);
        // Reset mid-HOLD
        cycle(1, 1, 0, 0, 0, 16'h0, 26'h0);
        cycle(1, 1, 0, 0, 1, 16'h0, 26'h0);
        cycle(0, 1, 1, 1, 1, 16'h0, 26'h0);
        chk("hold_reset_pc", pc, RESET_PC);
        cycle(1, 0, 0, 0, 1, 16'h0, 26'h55);
        cycle(1, 0, 0, 0, 0, 16'h0, 26'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) != 0,
                  $urandom_range(0, 3) == 0,
                  1'($urandom()), 1'($urandom()),
                  $urandom_range(0, 4) == 0,
                  16'($urandom()), 26'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
